// File: rtl/spi_read_pkg.sv
// Shared types and default geometry for the SPI read controller.
package spi_read_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SETUP,
        SHIFT,
        DONE
    } state_e;

    localparam int CLK_DIV       = 4;
    localparam int FRAME_BITS    = 16;
    localparam int DATA_MSB      = 12;
    localparam int DATA_LSB      = 5;
    localparam int SPI_PAYLOAD_W = DATA_MSB - DATA_LSB + 1;

endpackage

// File: rtl/spi_read_ctrl_sclk_gen.sv
// SCLK generator: half-period counter and phase flop; SCLK parks high while en=0.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold,
    output logic sclk,
    output logic half_tick,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    // Parking the counter at its wrap value makes the first enabled edge a falling edge.
    assign half_tick = en && (cnt_q == CNT_MAX);
    assign rise_tick = half_tick && !hold && !sclk_q;
    assign fall_tick = half_tick && !hold && sclk_q;
    assign sclk      = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = CNT_MAX;
            sclk_d = 1'b1;
        end else if (half_tick) begin
            cnt_d = '0;
            if (!hold) sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= CNT_MAX;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_read_ctrl.sv
// SPI read controller for a 16-bit read-only ADC-style peripheral.
// Define SPI_READ_CHECK_EN to flag frames whose non-payload bits are not zero.
module spi_read_ctrl #(
    parameter int CLK_DIV    = spi_read_pkg::CLK_DIV,
    parameter int FRAME_BITS = spi_read_pkg::FRAME_BITS,
    parameter int DATA_MSB   = spi_read_pkg::DATA_MSB,
    parameter int DATA_LSB   = spi_read_pkg::DATA_LSB
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         SDO,
    output logic                         SCLK,
    output logic                         CS,
    output logic [FRAME_BITS-1:0]        rx_word,
    output logic [DATA_MSB-DATA_LSB:0]   data,
    output logic                         valid,
    output logic                         busy,
    output logic                         err
);

    import spi_read_pkg::*;

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS);

    state_e                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [FRAME_BITS-1:0] rx_word_q;
    logic                  sdo_q;
    logic                  cs_q, cs_d;
    logic                  valid_q;

    logic en, hold, sclk, half_tick, rise_tick, fall_tick;

    // hold keeps SCLK high across PRE->SETUP and after the last data bit.
    assign en   = (state_q == IDLE && start) || state_q == PRE ||
                  state_q == SETUP || state_q == SHIFT;
    assign hold = (state_q == PRE && sclk) ||
                  (state_q == SHIFT && bit_cnt_q == LAST_BIT);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .hold     (hold),
        .sclk     (sclk),
        .half_tick(half_tick),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        case (state_q)
            IDLE:  if (start) state_d = PRE;
            PRE:   if (half_tick && sclk) state_d = SETUP;
            SETUP: begin
                bit_cnt_d = '0;
                if (fall_tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (rise_tick) begin
                    sr_d      = {sr_q[FRAME_BITS-2:0], sdo_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (half_tick && bit_cnt_q == LAST_BIT) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cs_d = !(state_d == SETUP || state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            sdo_q     <= 1'b0;
            cs_q      <= 1'b1;
            rx_word_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            sdo_q     <= SDO;
            cs_q      <= cs_d;
            valid_q   <= (state_q == DONE);
            if (state_q == DONE) rx_word_q <= sr_q;
        end
    end

`ifdef SPI_READ_CHECK_EN
    localparam int PW = DATA_MSB - DATA_LSB + 1;
    localparam logic [FRAME_BITS-1:0] PAY_MASK =
        FRAME_BITS'(((64'd1 << PW) - 64'd1) << DATA_LSB);

    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else if (state_q == DONE) err_q <= |(sr_q & ~PAY_MASK);
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign SCLK    = sclk;
    assign CS      = cs_q;
    assign rx_word = rx_word_q;
    assign data    = rx_word_q[DATA_MSB:DATA_LSB];
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_read_ctrl.sv
// Bench for spi_read_ctrl: peripheral model, cycle-offset timeline model, directed frames.
module tb_spi_read_ctrl;

    localparam int D    = 4;
    localparam int F    = 16;
    localparam int VLAT = 2 * D * (F + 1) + D + 1;

    logic        clk = 1'b0;
    logic        rst_n, start, SDO;
    logic        SCLK, CS, valid, busy, err;
    logic [15:0] rx_word;
    logic [7:0]  data;

    spi_read_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .SDO    (SDO),
        .SCLK   (SCLK),
        .CS     (CS),
        .rx_word(rx_word),
        .data   (data),
        .valid  (valid),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 50)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Peripheral: loads a word on any SCLK fall with CS high, shifts MSB first otherwise.
    logic [15:0] periph_word = 16'h0;
    logic [15:0] p_sr = 16'h0;
    int n_fall = 0, n_fall_cs = 0;
    initial SDO = 1'b0;

    always @(negedge SCLK) begin
        n_fall <= n_fall + 1;
        if (CS) p_sr <= periph_word;
        else begin
            n_fall_cs <= n_fall_cs + 1;
            SDO       <= p_sr[15];
            p_sr      <= {p_sr[14:0], 1'b0};
        end
    end

    function automatic logic exp_err_of(input logic [15:0] w);
`ifdef SPI_READ_CHECK_EN
        return |(w & 16'hE01F);
`else
        return 1'b0;
`endif
    endfunction

    // Model: mk = cycles since the edge that accepted start (-1 when idle).
    int          cyc = 0;
    int          mk = -1;
    logic [15:0] m_word = 16'h0, exp_rx = 16'h0;
    logic        exp_err = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mk      <= -1;
            exp_rx  <= 16'h0;
            exp_err <= 1'b0;
        end else if ((mk < 0 || mk >= VLAT) && start) begin
            mk     <= 0;
            m_word <= periph_word;
        end else if (mk >= VLAT) begin
            mk <= -1;
        end else if (mk >= 0) begin
            mk <= mk + 1;
            if (mk == VLAT - 1) begin
                exp_rx  <= m_word;
                exp_err <= exp_err_of(m_word);
            end
        end
    end

    function automatic logic e_sclk(input int k);
        if (k < 0)                 return 1'b1;
        if (k < D)                 return 1'b0;
        if (k < 3 * D)             return 1'b1;
        if (k < 3 * D + 2 * D * F) return ((k - 3 * D) % (2 * D)) >= D;
        return 1'b1;
    endfunction

    function automatic logic e_cs(input int k);
        return !(k >= 2 * D && k < 3 * D + 2 * D * F);
    endfunction

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sclk",    SCLK,    e_sclk(mk));
            check("cs",      CS,      e_cs(mk));
            check("busy",    busy,    (mk >= 0 && mk < VLAT));
            check("valid",   valid,   (mk == VLAT));
            check("rx_word", rx_word, exp_rx);
            check("data",    data,    exp_rx[12:5]);
            check("err",     err,     exp_err);
        end
    end

    // Valid pulse count and shortest CS-high gap between frames.
    int n_valid = 0;
    bit gap_arm = 0, seen_low = 0, cs_prev = 1;
    int hi_run = 0, min_gap = 999;

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
        cs_prev <= CS;
        if (!gap_arm) begin
            seen_low <= 0;
            hi_run   <= 0;
            min_gap  <= 999;
        end else if (CS) begin
            hi_run <= hi_run + 1;
        end else begin
            if (cs_prev && seen_low && hi_run < min_gap) min_gap <= hi_run;
            hi_run   <= 0;
            seen_low <= 1;
        end
    end

    task automatic run_frame(input logic [15:0] w, output int lat);
        int s;
        bit got;
        periph_word = w;
        @(negedge clk);
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        lat   = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            if (valid) begin
                got = 1;
                lat = cyc - s;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0]  pays [4];
        int          lat, v0, f0, fc0, s;
        logic        err_lit;
        pays = '{8'hA5, 8'h00, 8'h5A, 8'h81};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (20) @(negedge clk);
        check("rst_cs",      CS,      1);
        check("rst_sclk",    SCLK,    1);
        check("rst_busy",    busy,    0);
        check("rst_valid",   valid,   0);
        check("rst_rx_word", rx_word, 0);
        check("rst_data",    data,    0);
        check("rst_err",     err,     0);

        // First frame, payload 0xFF
        f0  = n_fall;
        fc0 = n_fall_cs;
        run_frame(16'h1FE0, lat);
        check("latency",     lat,             141);
        check("f1_rx_word",  rx_word,         16'h1FE0);
        check("f1_data",     data,            8'hFF);
        check("f1_err",      err,             0);
        check("f1_falls",    n_fall - f0,     17);
        check("f1_falls_cs", n_fall_cs - fc0, 16);

        // Back-to-back frames at the minimum period
        @(negedge clk);
        v0 = n_valid;
        for (int i = 0; i < 4; i++) begin
            run_frame({3'b000, pays[i], 5'b00000}, lat);
            check("b2b_data", data, pays[i]);
        end
        repeat (2) @(negedge clk);
        check("b2b_valids", n_valid - v0, 4);

        // start held for 300 cycles
        periph_word = 16'h0B40;
        v0 = n_valid;
        gap_arm = 1;
        @(negedge clk);
        start = 1'b1;
        repeat (300) @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("held_frames", n_valid - v0, 3);
        check("cs_gap",      min_gap,      2 * D + 2);
        gap_arm = 0;

        // Reset at cycle 60 of a frame
        periph_word = 16'h0660;
        @(negedge clk);
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 59) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_cs",   CS,   1);
        check("abort_sclk", SCLK, 1);
        check("abort_busy", busy, 0);
        v0 = n_valid;
        repeat (200) @(negedge clk);
        check("abort_no_valid", n_valid - v0, 0);
        run_frame(16'h0780, lat);
        check("post_abort_data", data, 8'h3C);
        check("post_abort_lat",  lat,  141);

        // Framing-check frame
`ifdef SPI_READ_CHECK_EN
        err_lit = 1'b1;
`else
        err_lit = 1'b0;
`endif
        run_frame(16'h1FE1, lat);
        check("chk_err",     err,     err_lit);
        check("chk_data",    data,    8'hFF);
        check("chk_rx_word", rx_word, 16'h1FE1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
